// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential restoring divider, one quotient bit per clock
// Loads on start, iterates N cycles, then presents held quotient/remainder with a one-cycle done.
module seq_divider #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         start,
  input  logic [N-1:0] n_in,
  input  logic [M-1:0] d_in,
  output logic [N-1:0] q_out,
  output logic [M-1:0] r_out,
  output logic         busy,
  output logic         done,
  output logic         div_zero
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [N-1:0]  q;
  logic [M-1:0]  r;
  logic [M-1:0]  d;

  logic [M:0]    t;
  logic [M:0]    diff;
  logic          ge;
  logic [M-1:0]  r_next;
  logic [N-1:0]  q_next;

  // The partial remainder stays below D, so its top bit is always zero and only M bits are stored.
  // The borrow out of the M+1 bit subtraction doubles as the "T < D" decision.
  always_comb begin
    t      = {r, q[N-1]};
    diff   = t - {1'b0, d};
    ge     = ~diff[M];
    r_next = ge ? diff[M-1:0] : t[M-1:0];
    q_next = {q[N-2:0], ge};
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= IDLE;
      count    <= '0;
      q        <= '0;
      r        <= '0;
      d        <= '0;
      q_out    <= '0;
      r_out    <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            q     <= n_in;
            r     <= '0;
            d     <= d_in;
            count <= '0;
            if (d_in != '0) begin
              state <= RUN;
            end else begin
              state    <= DONE;
              q_out    <= '1;
              r_out    <= '0;
              div_zero <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          q <= q_next;
          r <= r_next;
          if (count == LAST) begin
            state    <= DONE;
            q_out    <= q_next;
            r_out    <= r_next;
            div_zero <= 1'b0;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed and exhaustive checks of seq_divider at N=8, M=4
module tb_seq_divider;

  localparam int N = 8;
  localparam int M = 4;

  logic         clk;
  logic         clr;
  logic         start;
  logic [N-1:0] n_in;
  logic [M-1:0] d_in;
  logic [N-1:0] q_out;
  logic [M-1:0] r_out;
  logic         busy;
  logic         done;
  logic         div_zero;

  int n_cmp;
  int n_bad;

  seq_divider #(.N(N), .M(M)) dut (
    .clk(clk), .clr(clr), .start(start), .n_in(n_in), .d_in(d_in),
    .q_out(q_out), .r_out(r_out), .busy(busy), .done(done), .div_zero(div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Accept one operation, then wait (bounded) for done; cyc counts edges after the accept edge.
  task automatic run_op(input logic [N-1:0] n, input logic [M-1:0] dv,
                        output int cyc, output logic busy_seen);
    start = 1'b1; n_in = n; d_in = dv;
    step();
    start = 1'b0; n_in = ~n; d_in = ~dv;
    busy_seen = busy;
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin
      step();
      cyc++;
      if (busy === 1'b1) busy_seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    clr = 1'b0; start = 1'b0; n_in = '0; d_in = '0;
    step(); step();
    n_cmp++; if ({q_out, r_out} !== '0) begin n_bad++; $display("FAIL reset_qr got %0d/%0d want 0/0", q_out, r_out); end
    n_cmp++; if ({busy, done, div_zero} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {busy, done, div_zero}); end
    clr = 1'b1;
    step();
  endtask

  task automatic test_basic;
    int cyc; logic bs;
    run_op(8'd200, 4'd7, cyc, bs);
    n_cmp++; if (cyc !== N) begin n_bad++; $display("FAIL basic_latency got %0d want %0d", cyc, N); end
    n_cmp++; if (bs !== 1'b1) begin n_bad++; $display("FAIL basic_busy got %b want 1", bs); end
    n_cmp++; if (q_out !== 8'd28 || r_out !== 4'd4 || div_zero !== 1'b0)
      begin n_bad++; $display("FAIL basic_result got %0d/%0d z%b want 28/4 z0", q_out, r_out, div_zero); end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (done !== 1'b0 || q_out !== 8'd28 || r_out !== 4'd4)
        begin n_bad++; $display("FAIL basic_hold got done%b %0d/%0d want done0 28/4", done, q_out, r_out); end
    end
  endtask

  task automatic test_values;
    int cyc; logic bs;
    logic [N-1:0] nv [3] = '{8'd255, 8'd5, 8'd0};
    logic [M-1:0] dv [3] = '{4'd15, 4'd9, 4'd1};
    logic [N-1:0] qv [3] = '{8'd17, 8'd0, 8'd0};
    logic [M-1:0] rv [3] = '{4'd0, 4'd5, 4'd0};
    for (int i = 0; i < 3; i++) begin
      run_op(nv[i], dv[i], cyc, bs);
      n_cmp++; if (cyc !== N || q_out !== qv[i] || r_out !== rv[i] || div_zero !== 1'b0)
        begin n_bad++; $display("FAIL values_%0d got cyc%0d %0d/%0d z%b want cyc%0d %0d/%0d z0",
                               i, cyc, q_out, r_out, div_zero, N, qv[i], rv[i]); end
      step();
    end
  endtask

  task automatic test_div_zero;
    int cyc; logic bs;
    run_op(8'd100, 4'd0, cyc, bs);
    n_cmp++; if (cyc !== 0) begin n_bad++; $display("FAIL dz_latency got %0d want 0", cyc); end
    n_cmp++; if (bs !== 1'b0) begin n_bad++; $display("FAIL dz_busy got %b want 0", bs); end
    n_cmp++; if (q_out !== 8'd255 || r_out !== 4'd0 || div_zero !== 1'b1)
      begin n_bad++; $display("FAIL dz_result got %0d/%0d z%b want 255/0 z1", q_out, r_out, div_zero); end
    step();
    n_cmp++; if (done !== 1'b0 || div_zero !== 1'b1)
      begin n_bad++; $display("FAIL dz_hold got done%b z%b want done0 z1", done, div_zero); end
    run_op(8'd9, 4'd3, cyc, bs);
    n_cmp++; if (cyc !== N || q_out !== 8'd3 || r_out !== 4'd0 || div_zero !== 1'b0)
      begin n_bad++; $display("FAIL dz_next got cyc%0d %0d/%0d z%b want cyc%0d 3/0 z0", cyc, q_out, r_out, div_zero, N); end
    step();
  endtask

  task automatic test_back_to_back;
    int cyc;
    start = 1'b1; n_in = 8'd200; d_in = 4'd7;
    step();
    start = 1'b0;
    step(); step();
    start = 1'b1; n_in = 8'd50; d_in = 4'd5;
    step();
    start = 1'b0; n_in = '0; d_in = '0;
    cyc = 3;
    while (done !== 1'b1 && cyc < 40) begin step(); cyc++; end
    n_cmp++; if (cyc !== N || q_out !== 8'd28 || r_out !== 4'd4)
      begin n_bad++; $display("FAIL ignore_busy got cyc%0d %0d/%0d want cyc%0d 28/4", cyc, q_out, r_out, N); end
    start = 1'b1; n_in = 8'd50; d_in = 4'd5;
    step();
    start = 1'b0; n_in = '0; d_in = '0;
    n_cmp++; if (busy !== 1'b1 || done !== 1'b0)
      begin n_bad++; $display("FAIL b2b_accept got busy%b done%b want busy1 done0", busy, done); end
    cyc = 0;
    while (done !== 1'b1 && cyc < 40) begin step(); cyc++; end
    n_cmp++; if (cyc !== N || q_out !== 8'd10 || r_out !== 4'd0)
      begin n_bad++; $display("FAIL b2b_result got cyc%0d %0d/%0d want cyc%0d 10/0", cyc, q_out, r_out, N); end
    step();
  endtask

  task automatic test_clear;
    int cyc; logic bs; logic seen;
    start = 1'b1; n_in = 8'd200; d_in = 4'd7;
    step();
    start = 1'b0;
    step(); step(); step();
    clr = 1'b0; start = 1'b1;
    step();
    clr = 1'b1; start = 1'b0;
    n_cmp++; if ({q_out, r_out} !== '0 || {busy, done, div_zero} !== 3'b000)
      begin n_bad++; $display("FAIL clr_mid got %0d/%0d flags%b want 0/0 flags000", q_out, r_out, {busy, done, div_zero}); end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL clr_quiet got activity %b want 0", seen); end
    run_op(8'd13, 4'd4, cyc, bs);
    n_cmp++; if (cyc !== N || q_out !== 8'd3 || r_out !== 4'd1)
      begin n_bad++; $display("FAIL clr_fresh got cyc%0d %0d/%0d want cyc%0d 3/1", cyc, q_out, r_out, N); end
    step();
  endtask

  task automatic test_sweep;
    int cyc; logic bs; int dones;
    logic [N-1:0] eq; logic [M-1:0] er;
    for (int n = 0; n < 256; n++) begin
      for (int dv = 0; dv < 16; dv++) begin
        eq = (dv == 0) ? 8'd255 : 8'(n / dv);
        er = (dv == 0) ? 4'd0 : 4'(n % dv);
        run_op(8'(n), 4'(dv), cyc, bs);
        n_cmp++; if (q_out !== eq || r_out !== er || div_zero !== (dv == 0) || cyc !== ((dv == 0) ? 0 : N))
          begin n_bad++; $display("FAIL sweep %0d/%0d got %0d/%0d z%b cyc%0d want %0d/%0d", n, dv, q_out, r_out, div_zero, cyc, eq, er); end
        dones = 0;
        step();
        if (done === 1'b1) dones++;
        step();
        if (done === 1'b1) dones++;
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL sweep_once %0d/%0d got %0d extra done want 0", n, dv, dones); end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    test_reset();
    test_basic();
    test_values();
    test_div_zero();
    test_back_to_back();
    test_clear();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
